instr_mem_loader: RTL and testbench

- Byte-stream boot loader that writes a program image into the instruction memory's write port at run time.
- Replaces simulation-only memory preloading; this is the writer side of the memory the core fetches from.
- Holds the core in reset while loading and releases it only after a verified image.
- Sits between a byte source (UART receiver or bench driver) and port B of the instruction dual-port RAM.

---
 rtl/instr_mem_loader.sv | 193 +++++++++++++++++++
 tb/tb_instr_mem_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Boot loader: parses a framed byte stream and writes the program image
// into the instruction RAM write port, holding the core until it checks.
//
// Ports:
//   clk, rst    system clock, async active-high reset
//   s_valid     byte valid from the source
//   s_data      byte from the source
//   s_ready     loader accepts a byte (1 in every state after reset)
//   mem_we      one-cycle word write strobe
//   mem_addr    word address of the write
//   mem_wdata   assembled instruction word
//   core_hold   1 = core held in reset
//   load_done   image loaded with a good checksum (sticky)
//   load_err    frame error (sticky)
//
// Frame: SYNC, LEN lo, LEN hi, LEN x 4 data bytes (LE), CSUM.
// ADDR_W must be at most 15 so the word count fits the 16-bit LEN field.
module instr_mem_loader #(
    parameter int          ADDR_W    = 10,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] LEN_MAX = 17'd1 << ADDR_W;

    state_t            state_q, state_d;
    logic [7:0]        sum_q, sum_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [1:0]        lane_q, lane_d;
    logic [ADDR_W:0]   wcnt_q, wcnt_d;
    logic [23:0]       asm_q, asm_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              rdy_q;

    logic              accept;
    logic [15:0]       len_full;
    logic [ADDR_W:0]   wcnt_inc;
    logic [7:0]        sum_add;

    assign accept   = s_valid & rdy_q;
    assign len_full = {s_data, len_lo_q};
    assign wcnt_inc = wcnt_q + {{ADDR_W{1'b0}}, 1'b1};
    assign sum_add  = sum_q + s_data;

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        len_lo_d = len_lo_q;
        len_d    = len_q;
        lane_d   = lane_q;
        wcnt_d   = wcnt_q;
        asm_d    = asm_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        hold_d   = hold_q;
        done_d   = done_q;
        err_d    = err_q;
        if (accept) begin
            unique case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    // SYNC restarts a load from any resting state
                    if (s_data == SYNC_BYTE) begin
                        state_d = S_LEN0;
                        sum_d   = 8'd0;
                        lane_d  = 2'd0;
                        wcnt_d  = '0;
                        hold_d  = 1'b1;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                    end
                end
                S_LEN0: begin
                    len_lo_d = s_data;
                    sum_d    = sum_add;
                    state_d  = S_LEN1;
                end
                S_LEN1: begin
                    sum_d = sum_add;
                    len_d = len_full[ADDR_W:0];
                    if ({1'b0, len_full} > LEN_MAX) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else if (len_full == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    sum_d  = sum_add;
                    lane_d = lane_q + 2'd1;
                    unique case (lane_q)
                        2'd0: asm_d[7:0]   = s_data;
                        2'd1: asm_d[15:8]  = s_data;
                        2'd2: asm_d[23:16] = s_data;
                        default: begin
                            // last lane: word goes out next cycle
                            we_d    = 1'b1;
                            addr_d  = wcnt_q[ADDR_W-1:0];
                            wdata_d = {s_data, asm_q};
                            wcnt_d  = wcnt_inc;
                            if (wcnt_inc == len_q) begin
                                state_d = S_CSUM;
                            end
                        end
                    endcase
                end
                S_CSUM: begin
                    if (s_data == sum_q) begin
                        state_d = S_DONE;
                        hold_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sum_q    <= 8'd0;
            len_lo_q <= 8'd0;
            len_q    <= '0;
            lane_q   <= 2'd0;
            wcnt_q   <= '0;
            asm_q    <= 24'd0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            hold_q   <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            len_lo_q <= len_lo_d;
            len_q    <= len_d;
            lane_q   <= lane_d;
            wcnt_q   <= wcnt_d;
            asm_q    <= asm_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdy_q    <= 1'b1;
        end
    end

    assign s_ready   = rdy_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign core_hold = hold_q;
    assign load_done = done_q;
    assign load_err  = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: random framed streams against a frame-level
// reference model, checked every cycle, plus hand-computed scenarios.
module tb_instr_mem_loader;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int          cyc;
        logic [9:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        core_hold;
    logic        load_done;
    logic        load_err;

    int  total = 0;
    int  bad   = 0;
    int  ncyc  = 0;
    bit  chk_en = 1'b0;

    // reference model state
    logic m_ready = 1'b0;
    logic m_hold  = 1'b1;
    logic m_done  = 1'b0;
    logic m_err   = 1'b0;
    bit   m_rst   = 1'b0;
    wr_t  expq[$];
    logic [31:0] shadow [1024];

    instr_mem_loader #(.ADDR_W(10), .SYNC_BYTE(8'hA5)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_hold (core_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", n, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        ncyc++;
        if (chk_en) begin
            chk("s_ready", {31'b0, s_ready}, {31'b0, m_ready});
            chk("core_hold", {31'b0, core_hold}, {31'b0, m_hold});
            chk("load_done", {31'b0, load_done}, {31'b0, m_done});
            chk("load_err", {31'b0, load_err}, {31'b0, m_err});
            while (expq.size() > 0 && expq[0].cyc < ncyc) begin
                chk("missed_write", 32'(expq[0].cyc), 32'(ncyc));
                void'(expq.pop_front());
            end
            if (expq.size() > 0 && expq[0].cyc == ncyc) begin
                chk("mem_we", {31'b0, mem_we}, 32'd1);
                chk("mem_addr", {22'b0, mem_addr}, {22'b0, expq[0].a});
                chk("mem_wdata", mem_wdata, expq[0].d);
                void'(expq.pop_front());
            end else begin
                chk("mem_we_idle", {31'b0, mem_we}, 32'd0);
            end
            if (m_rst) begin
                chk("rst_addr", {22'b0, mem_addr}, 32'd0);
                chk("rst_wdata", mem_wdata, 32'd0);
            end
            if (mem_we === 1'b1) shadow[mem_addr] = mem_wdata;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2;
        s_valid = 1'b0;
        rst     = 1'b1;
        m_rst   = 1'b1;
        m_ready = 1'b0;
        m_hold  = 1'b1;
        m_done  = 1'b0;
        m_err   = 1'b0;
        expq.delete();
        #1;
        // asynchronous: outputs must already be at reset values
        chk("async_ready", {31'b0, s_ready}, 32'd0);
        chk("async_we", {31'b0, mem_we}, 32'd0);
        chk("async_hold", {31'b0, core_hold}, 32'd1);
        chk("async_done", {31'b0, load_done}, 32'd0);
        chk("async_err", {31'b0, load_err}, 32'd0);
        chk("async_addr", {22'b0, mem_addr}, 32'd0);
        chk("async_wdata", mem_wdata, 32'd0);
        chk_en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        m_rst = 1'b0;
        @(posedge clk);
        m_ready = 1'b1;
        #1;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // byte that the loader must ignore (never SYNC)
    task automatic send_junk(input logic [7:0] b, input int gap);
        idle(gap);
        s_valid = 1'b1;
        s_data  = b;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    function automatic bq_t make_frame(input int len, input bit corrupt);
        bq_t         f;
        logic [7:0]  s;
        logic [15:0] l;
        l = 16'(len);
        f.push_back(8'hA5);
        f.push_back(l[7:0]);
        f.push_back(l[15:8]);
        for (int i = 0; i < 4 * len; i++) f.push_back(8'($urandom));
        s = 8'd0;
        for (int i = 1; i < f.size(); i++) s = s + f[i];
        f.push_back(corrupt ? s + 8'd1 : s);
        return f;
    endfunction

    // Sends the first ncut bytes of frame f and advances the model on
    // every accepted byte by its role within the frame.
    task automatic send_frame(input bq_t f, input int ncut, input int gmax);
        int         len;
        int         w;
        logic [7:0] s;
        len = (f.size() >= 3) ? (int'(f[2]) * 256 + int'(f[1])) : 0;
        for (int k = 0; k < ncut; k++) begin
            idle($urandom_range(0, gmax));
            s_valid = 1'b1;
            s_data  = f[k];
            @(posedge clk);
            if (k == 0) begin
                m_hold = 1'b1;
                m_done = 1'b0;
                m_err  = 1'b0;
            end
            if (k == 2 && len > 1024) m_err = 1'b1;
            if (len <= 1024 && k >= 3 && k < 3 + 4 * len
                && (k - 3) % 4 == 3) begin
                w = (k - 3) / 4;
                expq.push_back('{ncyc + 1, 10'(w),
                                 {f[k], f[k-1], f[k-2], f[k-3]}});
            end
            if (len <= 1024 && k == 3 + 4 * len) begin
                s = 8'd0;
                for (int i = 1; i < k; i++) s = s + f[i];
                if (f[k] == s) begin
                    m_done = 1'b1;
                    m_hold = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
            end
            #1;
            s_valid = 1'b0;
        end
    endtask

    bq_t f1;
    bq_t fr;

    initial begin
        s_valid = 1'b0;
        s_data  = 8'h00;
        f1 = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00, 8'hB8};
        for (int i = 0; i < 1024; i++) shadow[i] = 32'hDEADBEEF;
        do_reset();

        // good two-word frame
        send_frame(f1, f1.size(), 0);
        idle(2);
        chk("s1_word0", shadow[0], 32'h00000013);
        chk("s1_word1", shadow[1], 32'h00100093);
        chk("s1_done", {31'b0, load_done}, 32'd1);
        chk("s1_hold", {31'b0, core_hold}, 32'd0);

        // same frame, bad checksum
        for (int i = 0; i < 2; i++) shadow[i] = 32'hDEADBEEF;
        f1[11] = 8'hB9;
        send_frame(f1, f1.size(), 0);
        idle(2);
        chk("s2_word1", shadow[1], 32'h00100093);
        chk("s2_err", {31'b0, load_err}, 32'd1);
        chk("s2_hold", {31'b0, core_hold}, 32'd1);
        chk("s2_done", {31'b0, load_done}, 32'd0);

        // junk ahead and gaps inside the frame
        f1[11] = 8'hB8;
        send_junk(8'h00, 1);
        send_junk(8'hFF, 2);
        send_junk(8'h5A, 0);
        send_frame(f1, f1.size(), 7);
        idle(2);
        chk("s3_done", {31'b0, load_done}, 32'd1);

        // empty image
        fr = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame(fr, fr.size(), 0);
        idle(2);
        chk("s4_done", {31'b0, load_done}, 32'd1);

        // LEN = 1025 is too long
        fr = '{8'hA5, 8'h01, 8'h04};
        send_frame(fr, fr.size(), 0);
        @(negedge clk);
        #1;
        chk("s5_err", {31'b0, load_err}, 32'd1);
        send_junk(8'h13, 0);
        send_junk(8'h00, 3);

        // reset during word 1, then a fresh frame
        send_frame(f1, 9, 1);
        do_reset();
        send_frame(f1, f1.size(), 2);
        idle(2);
        chk("s6_done", {31'b0, load_done}, 32'd1);

        // randomized frames with junk and gaps
        for (int r = 0; r < 40; r++) begin
            int nj;
            logic [7:0] jb;
            nj = $urandom_range(0, 3);
            for (int j = 0; j < nj; j++) begin
                jb = 8'($urandom);
                if (jb == 8'hA5) jb = 8'h00;
                send_junk(jb, $urandom_range(0, 3));
            end
            fr = make_frame($urandom_range(0, 8), ($urandom_range(0, 3) == 0));
            send_frame(fr, fr.size(), $urandom_range(0, 3));
        end

        // full-capacity image
        fr = make_frame(1024, 1'b0);
        send_frame(fr, fr.size(), 0);
        idle(2);
        chk("full_done", {31'b0, load_done}, 32'd1);
        idle(3);

        chk("pending_writes", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
